// File: rtl/rca_pkg.sv
// Shared limits, segment-width derivation and the stage payload type for rca_pipe_adder.
package rca_pkg;

  localparam int RCA_MIN_WIDTH  = 2;
  localparam int RCA_MAX_WIDTH  = 64;
  localparam int RCA_MIN_STAGES = 1;

  // Fields are sized for the widest legal adder; narrower builds leave the upper bits at zero.
  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [RCA_MAX_WIDTH-1:0] psum;
    logic [RCA_MAX_WIDTH-1:0] a_rem;
    logic [RCA_MAX_WIDTH-1:0] b_rem;
  } rca_stage_t;

  function automatic int rca_seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Purely combinational SEG-bit ripple-carry segment.
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);

  logic [SEG:0] chain_s;

  // Ripple the carry bit by bit through the segment
  always_comb begin
    chain_s    = '0;
    s_seg      = '0;
    chain_s[0] = c_in;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i]       = a_seg[i] ^ b_seg[i] ^ chain_s[i];
      chain_s[i + 1] = (a_seg[i] & b_seg[i]) | (chain_s[i] & (a_seg[i] ^ b_seg[i]));
    end
    c_out = chain_s[SEG];
  end

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder: STAGES segments of WIDTH/STAGES bits behind a valid/ready handshake.
// Optional feature: define RCA_PIPE_OVF_EN to add the two's-complement overflow output ovf.
module rca_pipe_adder
  import rca_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG  = rca_seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if (WIDTH < RCA_MIN_WIDTH || WIDTH > RCA_MAX_WIDTH || STAGES < RCA_MIN_STAGES ||
      STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("rca_pipe_adder: illegal WIDTH=%0d STAGES=%0d", WIDTH, STAGES);
  end

  rca_stage_t     pipe_q     [STAGES];
  rca_stage_t     pipe_d     [STAGES];
  logic [SEG-1:0] seg_a_s    [STAGES];
  logic [SEG-1:0] seg_b_s    [STAGES];
  logic [SEG-1:0] seg_sum_s  [STAGES];
  logic           seg_cin_s  [STAGES];
  logic           seg_cout_s [STAGES];
  logic           advance_s;
  logic           unused_bits;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    rca_seg #(.SEG(SEG)) u_seg (
      .a_seg (seg_a_s[k]),
      .b_seg (seg_b_s[k]),
      .c_in  (seg_cin_s[k]),
      .s_seg (seg_sum_s[k]),
      .c_out (seg_cout_s[k])
    );
  end

  // Handshake: the whole pipe moves unless a finished result is waiting on the consumer
  always_comb begin
    advance_s = !pipe_q[LAST].valid || out_ready;
    in_ready  = advance_s && !rst;
    out_valid = pipe_q[LAST].valid;
    sum       = {pipe_q[LAST].carry, pipe_q[LAST].psum[WIDTH-1:0]};
  end

  // Segment k adds its slice from the skewed operands and the carry left by stage k-1
  always_comb begin
    seg_a_s[0]   = a[SEG-1:0];
    seg_b_s[0]   = b[SEG-1:0];
    seg_cin_s[0] = cin;
    for (int k = 1; k < STAGES; k++) begin
      seg_a_s[k]   = pipe_q[k-1].a_rem[k*SEG +: SEG];
      seg_b_s[k]   = pipe_q[k-1].b_rem[k*SEG +: SEG];
      seg_cin_s[k] = pipe_q[k-1].carry;
    end
  end

  // Next payload per stage: consumed operand bits are zeroed, finished sum bits travel on
  always_comb begin
    pipe_d[0]                    = '0;
    pipe_d[0].valid              = in_valid;
    pipe_d[0].a_rem[WIDTH-1:0]   = a;
    pipe_d[0].b_rem[WIDTH-1:0]   = b;
    pipe_d[0].carry              = seg_cout_s[0];
    pipe_d[0].psum[SEG-1:0]      = seg_sum_s[0];
    pipe_d[0].a_rem[SEG-1:0]     = '0;
    pipe_d[0].b_rem[SEG-1:0]     = '0;
    for (int k = 1; k < STAGES; k++) begin
      pipe_d[k]                      = pipe_q[k-1];
      pipe_d[k].carry                = seg_cout_s[k];
      pipe_d[k].psum[k*SEG +: SEG]   = seg_sum_s[k];
      pipe_d[k].a_rem[k*SEG +: SEG]  = '0;
      pipe_d[k].b_rem[k*SEG +: SEG]  = '0;
    end
  end

  // Stage registers: cleared by reset, shifted together on advance, frozen otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (advance_s) begin
      for (int k = 0; k < STAGES; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

`ifdef RCA_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Sign bits reach the last stage through the operand skew path, so overflow lines up with sum
  always_comb begin
    ovf_d = (seg_a_s[LAST][SEG-1] == seg_b_s[LAST][SEG-1]) &&
            (seg_sum_s[LAST][SEG-1] != seg_a_s[LAST][SEG-1]);
  end

  // Overflow flag register, moves with the final stage
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance_s) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  // Payload bits above WIDTH and already-consumed skew bits are intentionally never read
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_bits = unused_bits ^ (^pipe_q[k]);
    end
  end

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Self-checking bench for rca_pipe_adder: 8-bit/2-stage directed and random traffic plus
// 16-bit builds with 1, 4 and 16 stages against a delay-line arithmetic model.
module tb_rca_pipe_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;
`ifdef RCA_PIPE_OVF_EN
  logic       ovf;
`endif

  logic        in_valid16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        cin16;
  logic        in_ready16  [3];
  logic        out_valid16 [3];
  logic [16:0] sum16       [3];
`ifdef RCA_PIPE_OVF_EN
  logic        ovf16       [3];
`endif
  logic        out_ready16;

  int n_err;
  int n_checks;
  int n16;
  bit done16;

  // Reference model state: one slot per pipeline stage, slot depth-1 is what the output shows
  bit         mv [2];
  logic [8:0] ms [2];
  bit         mo [2];
  logic [8:0] sbq [$];
  bit          v16 [3][16];
  logic [16:0] s16 [3][16];
  bit          o16 [3][16];

  rca_pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum)
`ifdef RCA_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  for (genvar g = 0; g < 3; g++) begin : g_w16
    localparam int DEP_G = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    rca_pipe_adder #(.WIDTH(16), .STAGES(DEP_G)) u_dut16 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16[g]),
      .a         (a16),
      .b         (b16),
      .cin       (cin16),
      .out_valid (out_valid16[g]),
      .out_ready (out_ready16),
      .sum       (sum16[g])
`ifdef RCA_PIPE_OVF_EN
      ,
      .ovf       (ovf16[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dep(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 16);
  endfunction

  function automatic logic [16:0] addw(input logic [15:0] x, input logic [15:0] y, input logic c);
    return 17'(x) + 17'(y) + 17'(c);
  endfunction

  // Overflow means the signed sum of the w-bit operands leaves the w-bit signed range
  function automatic bit sovf(input logic [15:0] x, input logic [15:0] y, input logic c, input int w);
    int sx;
    int sy;
    int s;
    sx = x[w-1] ? (int'(x) - (1 << w)) : int'(x);
    sy = y[w-1] ? (int'(y) - (1 << w)) : int'(y);
    s  = sx + sy + int'(c);
    return (s > ((1 << (w - 1)) - 1)) || (s < -(1 << (w - 1)));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input bit v, input logic [7:0] x, input logic [7:0] y, input logic c);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = c;
  endtask

  // Compare every cycle against the model, then advance the model for the coming edge
  always @(negedge clk) begin : compare
    bit e_ov;
    bit e_ir;
    e_ov = mv[1];
    e_ir = !rst && (!e_ov || out_ready);
    chk("m_in_ready", 64'(in_ready), 64'(e_ir));
    chk("m_out_valid", 64'(out_valid), 64'(e_ov));
    if (e_ov) begin
      chk("m_sum", 64'(sum), 64'(ms[1]));
`ifdef RCA_PIPE_OVF_EN
      chk("m_ovf", 64'(ovf), 64'(mo[1]));
`endif
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) chk("m_retire_without_accept", 64'(sbq.size()), 64'(1));
      else chk("m_order", 64'(sum), 64'(sbq.pop_front()));
    end
    if (rst) begin
      mv[0] = 1'b0;
      mv[1] = 1'b0;
      sbq.delete();
    end else if (!e_ov || out_ready) begin
      mv[1] = mv[0];
      ms[1] = ms[0];
      mo[1] = mo[0];
      mv[0] = in_valid;
      ms[0] = 9'(addw(16'(a), 16'(b), cin));
      mo[0] = sovf(16'(a), 16'(b), cin, 8);
      if (in_valid) sbq.push_back(ms[0]);
    end

    for (int i = 0; i < 3; i++) begin
      int d;
      d = dep(i);
      chk("w16_in_ready", 64'(in_ready16[i]), 64'(!rst));
      chk("w16_out_valid", 64'(out_valid16[i]), 64'(v16[i][d-1]));
      if (v16[i][d-1]) begin
        chk("w16_sum", 64'(sum16[i]), 64'(s16[i][d-1]));
`ifdef RCA_PIPE_OVF_EN
        chk("w16_ovf", 64'(ovf16[i]), 64'(o16[i][d-1]));
`endif
      end
      if (rst) begin
        for (int j = 0; j < d; j++) v16[i][j] = 1'b0;
      end else begin
        for (int j = d - 1; j > 0; j--) begin
          v16[i][j] = v16[i][j-1];
          s16[i][j] = s16[i][j-1];
          o16[i][j] = o16[i][j-1];
        end
        v16[i][0] = in_valid16;
        s16[i][0] = addw(a16, b16, cin16);
        o16[i][0] = sovf(a16, b16, cin16, 16);
      end
    end
    if (!rst && in_valid16) n16++;
  end

  // Streaming random traffic for the 16-bit builds, with occasional all-ones carry chains
  initial begin
    in_valid16  = 1'b0;
    a16         = 16'h0000;
    b16         = 16'h0000;
    cin16       = 1'b0;
    out_ready16 = 1'b1;
    done16      = 1'b0;
    while (n16 < 10000) begin
      step();
      in_valid16 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 63) == 0) begin
        a16   = 16'hFFFF;
        b16   = 16'hFFFF;
        cin16 = 1'b1;
      end else begin
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom_range(0, 1));
      end
    end
    step();
    in_valid16 = 1'b0;
    done16     = 1'b1;
  end

  initial begin
    logic [8:0] p1;
    int guard;
    rst = 1'b1;
    out_ready = 1'b1;
    put(1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
`ifdef RCA_PIPE_OVF_EN
    chk("rst_ovf", 64'(ovf), 64'(0));
`endif

    step(); rst = 1'b0; put(1'b1, 8'd200, 8'd190, 1'b0);
    @(negedge clk); chk("ready_after_rst", 64'(in_ready), 64'(1));
    step(); put(1'b1, 8'd255, 8'd255, 1'b1);
    @(negedge clk); chk("latency_not_early", 64'(out_valid), 64'(0));
    step(); put(1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk); chk("lat2_valid_a", 64'(out_valid), 64'(1)); chk("sum_390", 64'(sum), 64'(9'd390));
    step();
    @(negedge clk); chk("lat2_valid_b", 64'(out_valid), 64'(1)); chk("sum_511", 64'(sum), 64'(9'd511));
    step();
    @(negedge clk); chk("bubble_kept", 64'(out_valid), 64'(0));

    for (int i = 0; i < 16; i++) begin
      step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    step(); in_valid = 1'b0;
    repeat (4) step();

    step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    p1 = 9'(addw(16'(a), 16'(b), cin));
    step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    step(); out_ready = 1'b0; put(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_sum", 64'(sum), 64'(p1));
    end
    step(); out_ready = 1'b1; put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    step(); in_valid = 1'b0;
    repeat (4) step();

    step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    step(); put(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    step(); rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    step();
    @(negedge clk); chk("rst_flush_valid", 64'(out_valid), 64'(0));
    step(); rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      @(negedge clk); chk("no_stale_result", 64'(out_valid), 64'(0));
    end

`ifdef RCA_PIPE_OVF_EN
    step(); put(1'b1, 8'h7F, 8'h01, 1'b0);
    step(); put(1'b1, 8'h80, 8'h80, 1'b0);
    step(); put(1'b1, 8'h10, 8'h20, 1'b0);
    @(negedge clk); chk("ovf_7f_sum", 64'(sum), 64'(9'h080)); chk("ovf_7f", 64'(ovf), 64'(1));
    step(); in_valid = 1'b0;
    @(negedge clk); chk("ovf_80_sum", 64'(sum), 64'(9'h100)); chk("ovf_80", 64'(ovf), 64'(1));
    step();
    @(negedge clk); chk("ovf_10_sum", 64'(sum), 64'(9'h030)); chk("ovf_10", 64'(ovf), 64'(0));
`endif

    for (int i = 0; i < 300; i++) begin
      step();
      put(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    step(); in_valid = 1'b0; out_ready = 1'b1;

    guard = 0;
    while (!done16 && guard < 40000) begin
      step();
      guard++;
    end
    chk("w16_stream_done", 64'(done16), 64'(1));
    repeat (20) step();
    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
